shreg_ctrl: RTL
===============

SHREG_CTRL -- requirements
Module: shreg_ctrl

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port cmd_valid  input  1  command offered.
REQ-004 SHALL have port cmd_ready  output  1  controller accepts a command this cycle.
REQ-005 SHALL have port cmd_op  input  2  00 LOAD, 01 SHR, 10 SHL, 11 ROTR/reserved (see Configuration).
REQ-006 SHALL have port cmd_cnt  input  4  shift count 0..15; ignored for LOAD.
REQ-007 SHALL have port cmd_data  input  4  parallel load word for LOAD.
REQ-008 SHALL have port cmd_fill  input  1  serial fill bit for SHR/SHL.
REQ-009 SHALL have port reg_s  output  2  register mode: 00 hold, 01 shift right (dr into bit3), 10 shift left (dl into bit0), 11 parallel load.
REQ-010 SHALL have ports reg_din  output  4, reg_dr  output  1, reg_dl  output  1  register data/serial inputs.
REQ-011 SHALL have port reg_q  input  4  current register contents.
REQ-012 SHALL have ports busy  output  1, done  output  1, err  output  1, result  output  4  status and captured register value.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-014 SHALL assert cmd_ready only in IDLE; a command is accepted on a cycle with cmd_valid=1 and cmd_ready=1.
REQ-015 SHALL latch cmd_op, cmd_cnt, cmd_data, cmd_fill on acceptance; later input changes SHALL have no effect on the command in progress.
REQ-016 SHALL, on acceptance, go to EXEC with a remaining count of 1 for LOAD and cmd_cnt for SHR/SHL/ROTR; a count of 0 SHALL go directly to DONE.
REQ-017 SHALL drive reg_s=11 and reg_din=latched data for LOAD, reg_s=01 with reg_dr=fill for SHR, and reg_s=10 with reg_dl=fill for SHL, in every EXEC cycle.
REQ-018 SHALL decrement the remaining count on each EXEC cycle and leave EXEC for DONE after the cycle in which it reaches 1; exactly N register-update edges SHALL occur.
REQ-019 SHALL drive reg_s=00 in IDLE and DONE; reg_din, reg_dr and reg_dl SHALL be 0 whenever they are not selected by REQ-017.
REQ-020 SHALL, in DONE, assert done for exactly one cycle, register reg_q into result (visible from the following cycle), and return to IDLE.
REQ-021 SHALL assert busy in EXEC and DONE only.
REQ-022 SHALL give command latency = N+2 cycles from acceptance to the next cmd_ready; back-to-back commands SHALL be accepted with no further gap.
REQ-023 SHALL hold result between commands.

Reset
REQ-024 SHALL, with rst=1 at a clock edge, enter IDLE with count=0, result=0, done=0, err=0, busy=0, reg_s=00, and reg_din/reg_dr/reg_dl=0.
REQ-025 SHALL, with rst asserted mid-command, abort the command without producing done, and SHALL drive reg_s=00 from the next cycle.
REQ-026 SHALL deassert cmd_ready while rst=1.

Configuration
REQ-027 SHALL support the macro SHREG_ROTATE_EN.
REQ-028 SHALL, with SHREG_ROTATE_EN defined, treat op 11 as ROTR: each EXEC cycle drives reg_s=01 and reg_dr=reg_q[0] (live), with err=0.
REQ-029 SHALL, without SHREG_ROTATE_EN, accept op 11, skip EXEC, go directly to DONE, and pulse err=1 together with done; the register SHALL remain held.

Verification
REQ-030 SHALL verify LOAD: cmd_op=00, cmd_data=1011 -> one EXEC cycle with reg_s=11; done pulse; result=1011 and busy low 3 cycles after acceptance.
REQ-031 SHALL verify SHR: after LOAD 1011, SHR with cnt=2 and fill=0 -> exactly 2 EXEC cycles with reg_s=01; result=0010.
REQ-032 SHALL verify SHL zero-count: SHL with cnt=0 -> no EXEC cycle, reg_s stays 00, done asserted the cycle after acceptance, result unchanged.
REQ-033 SHALL verify ROTR: after LOAD 1001, op 11 with cnt=1 -> with SHREG_ROTATE_EN, result=1100 and err=0; without it, result=1001 and err=1.
REQ-034 SHALL verify mid-command reset: SHL with cnt=8, rst asserted on the 3rd EXEC cycle -> no done pulse, reg_s=00 and result=0 after reset, cmd_ready=1 the cycle after rst drops.
REQ-035 SHALL verify back-to-back: cmd_valid held high for two SHR commands with cnt=1 -> the second is accepted exactly 3 cycles after the first.

Source files
------------

// File: rtl/shreg_ctrl_if.sv
// Command, register-control and status bundle for shreg_ctrl.
// The slave side is the controller; the master side is the command source and shift register.
interface shreg_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_cnt;
    logic [3:0] cmd_data;
    logic       cmd_fill;
    logic [1:0] reg_s;
    logic [3:0] reg_din;
    logic       reg_dr;
    logic       reg_dl;
    logic [3:0] reg_q;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] result;

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill, reg_q,
        output cmd_ready, reg_s, reg_din, reg_dr, reg_dl, busy, done, err, result
    );

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill, reg_q,
        input  cmd_ready, reg_s, reg_din, reg_dr, reg_dl, busy, done, err, result
    );
endinterface

// File: rtl/shreg_ctrl.sv
// Sequencer for an external 4-bit universal shift register: LOAD / SHR / SHL / op 11.
// Define SHREG_ROTATE_EN to make op 11 a rotate-right; otherwise op 11 is reported as an error.
module shreg_ctrl (
    input logic         clk,
    input logic         rst,
    shreg_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e     r_state;
    state_e     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [1:0] r_op;
    logic [3:0] r_data;
    logic       r_fill;
    logic [3:0] r_result;
    logic       w_accept;
    logic [3:0] w_start_cnt;

    assign w_accept = (r_state == StIdle) && bus.cmd_valid && !rst;

    always_comb begin
        w_start_cnt = bus.cmd_cnt;
        unique case (bus.cmd_op)
            2'b00: w_start_cnt = 4'd1;
            2'b01: w_start_cnt = bus.cmd_cnt;
            2'b10: w_start_cnt = bus.cmd_cnt;
            2'b11: begin
`ifdef SHREG_ROTATE_EN
                w_start_cnt = bus.cmd_cnt;
`else
                w_start_cnt = 4'd0;
`endif
            end
            default: w_start_cnt = bus.cmd_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cnt    <= 4'd0;
            r_op     <= 2'b00;
            r_data   <= 4'd0;
            r_fill   <= 1'b0;
            r_result <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_op   <= bus.cmd_op;
                r_data <= bus.cmd_data;
                r_fill <= bus.cmd_fill;
            end
            if (r_state == StDone) begin
                r_result <= bus.reg_q;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_cnt_nxt   = w_start_cnt;
                    w_state_nxt = (w_start_cnt == 4'd0) ? StDone : StExec;
                end
            end
            StExec: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        bus.cmd_ready = (r_state == StIdle) && !rst;
        bus.busy      = (r_state == StExec) || (r_state == StDone);
        bus.done      = (r_state == StDone);
`ifdef SHREG_ROTATE_EN
        bus.err       = 1'b0;
`else
        bus.err       = (r_state == StDone) && (r_op == 2'b11);
`endif
        bus.result    = r_result;
        bus.reg_s     = 2'b00;
        bus.reg_din   = 4'd0;
        bus.reg_dr    = 1'b0;
        bus.reg_dl    = 1'b0;
        if (r_state == StExec) begin
            unique case (r_op)
                2'b00: begin
                    bus.reg_s   = 2'b11;
                    bus.reg_din = r_data;
                end
                2'b01: begin
                    bus.reg_s  = 2'b01;
                    bus.reg_dr = r_fill;
                end
                2'b10: begin
                    bus.reg_s  = 2'b10;
                    bus.reg_dl = r_fill;
                end
                2'b11: begin
`ifdef SHREG_ROTATE_EN
                    // Rotation feeds the live LSB back into bit 3.
                    bus.reg_s  = 2'b01;
                    bus.reg_dr = bus.reg_q[0];
`endif
                end
                default: begin
                    bus.reg_s = 2'b00;
                end
            endcase
        end
    end
endmodule
